// File: rtl/debug_hex_tx_pkg.sv
// Shared constants and state encoding for the debug hex transmitter.
// Imported by the top and the byte FIFO.
package debug_hex_tx_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_SEP,
    ST_CR,
    ST_LF
  } tx_state_t;

endpackage

// File: rtl/debug_byte_fifo.sv
// Generic synchronous byte FIFO with wrap-bit pointers.
// Full and empty come straight from the registered pointers.
module debug_byte_fifo
  import debug_hex_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_empty = (wr_ptr == rd_ptr);
  assign o_data  = mem[rd_ptr[AW-1:0]];

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // NOTE: the storage array has no reset; only the pointers define which
  // entries are valid, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/debug_hex_tx.sv
// Renders buffered debug bytes as "HH " ASCII hex with CR/LF line breaks
// every LINE_BYTES bytes or on request, over a valid/ready character port.
module debug_hex_tx
  import debug_hex_tx_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         LINE_BYTES = 16,
  parameter logic [7:0] SEP_CHAR   = 8'h20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_flush,
  output logic [7:0] o_wdata,
  output logic       o_wvalid,
  input  logic       i_wready,
  output logic       o_drop,
  output logic [7:0] o_drop_cnt
);

  localparam logic [7:0] LINE_LAST = 8'(LINE_BYTES - 1);

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'h0, nib};
    return ASCII_A + {4'h0, nib} - 8'd10;
  endfunction

  tx_state_t  state;
  logic [7:0] hold_byte;
  logic [7:0] line_cnt;
  logic       flush_pend;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_push;
  logic       fifo_pop;
  logic       wxfer;
  logic       load_next;

  assign o_ready   = !fifo_full;
  assign fifo_push = i_valid && !fifo_full;
  assign wxfer     = o_wvalid && i_wready;

  // Start a new byte from IDLE, or straight out of SEP/LF to skip the bubble.
  assign load_next = !fifo_empty &&
                     ((state == ST_IDLE) ||
                      (wxfer && ((state == ST_SEP) || (state == ST_LF))));
  assign fifo_pop  = load_next;

  debug_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (fifo_push),
    .i_data  (i_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drop     <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_drop <= i_valid && fifo_full;
      if (i_valid && fifo_full && (o_drop_cnt != 8'hFF))
        o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      o_wdata    <= '0;
      o_wvalid   <= 1'b0;
      hold_byte  <= '0;
      line_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (i_flush) flush_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          // An empty line has nothing to terminate, so a flush is dropped.
          if (line_cnt == '0) begin
            flush_pend <= 1'b0;
          end else if (fifo_empty && flush_pend) begin
            o_wdata  <= ASCII_CR;
            o_wvalid <= 1'b1;
            state    <= ST_CR;
          end
        end

        ST_HI: begin
          if (wxfer) begin
            o_wdata <= hex_char(hold_byte[3:0]);
            state   <= ST_LO;
          end
        end

        ST_LO: begin
          if (wxfer) begin
            line_cnt <= line_cnt + 8'd1;
            if ((line_cnt == LINE_LAST) || flush_pend) begin
              o_wdata <= ASCII_CR;
              state   <= ST_CR;
            end else begin
              o_wdata <= SEP_CHAR;
              state   <= ST_SEP;
            end
          end
        end

        ST_SEP: begin
          if (wxfer) begin
            o_wvalid <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        ST_CR: begin
          if (wxfer) begin
            o_wdata <= ASCII_LF;
            state   <= ST_LF;
          end
        end

        ST_LF: begin
          if (wxfer) begin
            o_wvalid   <= 1'b0;
            line_cnt   <= '0;
            flush_pend <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Loading a fresh byte overrides the idle-bound updates above.
      if (load_next) begin
        hold_byte <= fifo_rdata;
        o_wdata   <= hex_char(fifo_rdata[7:4]);
        o_wvalid  <= 1'b1;
        state     <= ST_HI;
      end
    end
  end

endmodule

// File: tb/tb_debug_hex_tx.sv
// Scoreboard bench for debug_hex_tx: expected characters are queued as bytes
// are offered and compared as the DUT hands characters to the UART side.
module tb_debug_hex_tx;

  localparam int LB = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_data = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       i_flush = 1'b0;
  logic [7:0] o_wdata;
  logic       o_wvalid;
  logic       i_wready = 1'b0;
  logic       o_drop;
  logic [7:0] o_drop_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         drop_pulses = 0;
  int         m_cnt = 0;
  logic [7:0] exp_q[$];
  string      hex_digits = "0123456789ABCDEF";

  debug_hex_tx #(
    .DEPTH      (16),
    .LINE_BYTES (LB),
    .SEP_CHAR   (8'h20)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_flush    (i_flush),
    .o_wdata    (o_wdata),
    .o_wvalid   (o_wvalid),
    .i_wready   (i_wready),
    .o_drop     (o_drop),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Formatting model: two hex digits, then separator or line end.
  task automatic expect_byte(input logic [7:0] b, input bit force_end);
    exp_q.push_back(8'(hex_digits[b[7:4]]));
    exp_q.push_back(8'(hex_digits[b[3:0]]));
    m_cnt++;
    if (m_cnt == LB || force_end) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_cnt = 0;
    end else begin
      exp_q.push_back(8'h20);
    end
  endtask

  // Characters transfer on the next rising edge; sample mid-cycle.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_drop) drop_pulses++;
      if (o_wvalid && i_wready) begin
        if (exp_q.size() == 0) check("extra_char", {24'h0, o_wdata}, 32'h100);
        else check("char", {24'h0, o_wdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit force_end);
    i_data = b;
    i_valid = 1'b1;
    expect_byte(b, force_end);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_wvalid(input int max_cycles);
    for (int i = 0; i < max_cycles && !o_wvalid; i++) begin
      @(posedge i_clk);
      #1;
    end
    if (!o_wvalid) check("wvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge i_clk);
      #1;
    end
    check({tag, "_left"}, exp_q.size(), 32'd0);
    repeat (8) @(posedge i_clk);
    #1 check({tag, "_idle"}, {31'h0, o_wvalid}, 32'd0);
  endtask

  initial begin
    int d0;

    #1;
    check("rst_wvalid", {31'h0, o_wvalid}, 32'd0);
    check("rst_wdata", {24'h0, o_wdata}, 32'd0);
    check("rst_ready", {31'h0, o_ready}, 32'd1);
    check("rst_drop", {31'h0, o_drop}, 32'd0);
    check("rst_dropcnt", {24'h0, o_drop_cnt}, 32'd0);

    // Single byte and first-character latency.
    do_reset();
    i_wready = 1'b1;
    push_byte(8'hA5, 1'b0);
    check("lat_n1", {31'h0, o_wvalid}, 32'd0);
    @(posedge i_clk);
    #1;
    check("lat_n2_valid", {31'h0, o_wvalid}, 32'd1);
    check("lat_n2_data", {24'h0, o_wdata}, 32'h41);
    drain("a5");

    // Full line of four bytes including nibble boundaries.
    do_reset();
    i_wready = 1'b1;
    push_byte(8'h00, 1'b0);
    push_byte(8'h01, 1'b0);
    push_byte(8'hFE, 1'b0);
    push_byte(8'hFF, 1'b0);
    drain("line");
    check("line_cnt_zero", {24'h0, dut.line_cnt}, 32'd0);

    // Stall on the HI character, then overflow the FIFO behind it.
    do_reset();
    i_wready = 1'b0;
    push_byte(8'h3C, 1'b0);
    wait_wvalid(10);
    for (int i = 0; i < 10; i++) begin
      check("stall_data", {24'h0, o_wdata}, 32'h33);
      check("stall_valid", {31'h0, o_wvalid}, 32'd1);
      @(posedge i_clk);
      #1;
    end
    d0 = drop_pulses;
    for (int i = 0; i < 20; i++) begin
      if (i == 15) check("ready_before_full", {31'h0, o_ready}, 32'd1);
      if (i == 16) check("ready_full", {31'h0, o_ready}, 32'd0);
      i_data = 8'h80 + 8'(i);
      i_valid = 1'b1;
      if (i < 16) expect_byte(8'h80 + 8'(i), 1'b0);
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check("drop_pulses", drop_pulses - d0, 32'd4);
    check("drop_cnt", {24'h0, o_drop_cnt}, 32'd4);
    check("stall_still", {24'h0, o_wdata}, 32'h33);
    i_wready = 1'b1;
    drain("overflow");
    check("ready_after_drain", {31'h0, o_ready}, 32'd1);

    // Flush during the HI character ends the line without a separator.
    do_reset();
    i_wready = 1'b1;
    push_byte(8'h12, 1'b1);
    wait_wvalid(10);
    check("flush_hi", {24'h0, o_wdata}, 32'h31);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    drain("flush");
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check("idle_flush_quiet", {31'h0, o_wvalid}, 32'd0);
    check("idle_flush_clear", {31'h0, dut.flush_pend}, 32'd0);

    // Asynchronous reset during the LO character abandons everything queued.
    do_reset();
    i_wready = 1'b0;
    push_byte(8'hA1, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    wait_wvalid(10);
    check("pre_rst_hi", {24'h0, o_wdata}, 32'h41);
    i_wready = 1'b1;
    @(posedge i_clk);
    #1 i_wready = 1'b0;
    check("pre_rst_lo", {24'h0, o_wdata}, 32'h31);
    #3 i_rst = 1'b1;
    exp_q.delete();
    m_cnt = 0;
    #1;
    check("rst_mid_wvalid", {31'h0, o_wvalid}, 32'd0);
    check("rst_mid_ready", {31'h0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk);
    #1 i_wready = 1'b1;
    push_byte(8'h7E, 1'b0);
    drain("post_rst");
    check("post_rst_linecnt", {24'h0, dut.line_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
